dense_mac_sequencer: RTL and testbench

Time-multiplexed controller for one fully-connected layer. It shares a single signed fixed-point multiply-accumulate across all NB_NEURONS outputs. For each neuron it walks the input vector, fetching weights from an external weight ROM at address j*STRIDE+i and adding the bias from a bias ROM. It applies the 1/256 weight scale as an arithmetic right shift, then streams each pre-activation value out over a valid/ready handshake to the downstream tanh/sigmoid LUT stage.

---
 rtl/dense_seq_pkg.sv | 28 ++
 rtl/dense_seq_mac.sv | 46 ++++
 rtl/dense_mac_sequencer.sv | 159 +++++++++++++++
 tb/tb_dense_mac_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dense_seq_pkg.sv
// rtl/dense_seq_pkg.sv - shared widths, FSM state encoding and saturation helper for the dense MAC sequencer
package dense_seq_pkg;

  localparam int FIXED_DEF = 32;
  localparam int FRAC_DEF  = 16;
  localparam int ACC_W_DEF = 48;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MAC  = 3'd1;
  localparam logic [2:0] ST_BIAS = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Clamp a signed accumulator-width value into the signed FIXED range.
  function automatic logic [FIXED_DEF-1:0] saturate(input logic signed [ACC_W_DEF-1:0] v);
    logic signed [ACC_W_DEF-1:0] hi;
    logic signed [ACC_W_DEF-1:0] lo;
    hi = {{(ACC_W_DEF-FIXED_DEF+1){1'b0}}, {(FIXED_DEF-1){1'b1}}};
    lo = {{(ACC_W_DEF-FIXED_DEF+1){1'b1}}, {(FIXED_DEF-1){1'b0}}};
    if (v > hi) begin
      return {1'b0, {(FIXED_DEF-1){1'b1}}};
    end else if (v < lo) begin
      return {1'b1, {(FIXED_DEF-1){1'b0}}};
    end
    return v[FIXED_DEF-1:0];
  endfunction

endpackage

// File: rtl/dense_seq_mac.sv
// rtl/dense_seq_mac.sv - signed fixed-point multiply with FRAC shift and clearable accumulator
module dense_seq_mac
  import dense_seq_pkg::*;
#(
  parameter int FIXED = FIXED_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    en_i,
  input  logic [FIXED-1:0]        a_i,
  input  logic [FIXED-1:0]        b_i,
  output logic signed [ACC_W-1:0] prod_o,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*FIXED-1:0] full;
  logic signed [ACC_W-1:0]   acc_q, acc_d;

  // Both operands are widened before multiplying so the full product is exact.
  assign full   = $signed({{FIXED{a_i[FIXED-1]}}, a_i}) * $signed({{FIXED{b_i[FIXED-1]}}, b_i});
  assign prod_o = ACC_W'(full >>> FRAC);
  assign acc_o  = acc_q;

  // Clear wins over accumulate; the sum wraps at ACC_W bits.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_o;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dense_mac_sequencer.sv
// rtl/dense_mac_sequencer.sv - time-multiplexed fully-connected layer sequencer; DENSE_SEQ_SAT_EN selects saturating output reduction
module dense_mac_sequencer
  import dense_seq_pkg::*;
#(
  parameter int FIXED       = FIXED_DEF,
  parameter int FRAC        = FRAC_DEF,
  parameter int NB_INPUT    = 42,
  parameter int NB_NEURONS  = 24,
  parameter int STRIDE      = 24,
  parameter int SCALE_SHIFT = 8,
  parameter int ACC_W       = ACC_W_DEF,
  localparam int AW = (NB_INPUT*STRIDE > 1) ? $clog2(NB_INPUT*STRIDE) : 1,
  localparam int IW = (NB_NEURONS > 1) ? $clog2(NB_NEURONS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NB_INPUT*FIXED-1:0] in_vec,
  output logic                      busy,
  output logic                      done,
  output logic                      w_rd_en,
  output logic [AW-1:0]             w_addr,
  input  logic [FIXED-1:0]          w_data,
  output logic                      b_rd_en,
  output logic [IW-1:0]             b_addr,
  input  logic [FIXED-1:0]          b_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IW-1:0]             out_idx,
  output logic [FIXED-1:0]          out_data
);

  localparam int JW = (NB_INPUT > 1) ? $clog2(NB_INPUT) : 1;

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    i_q, i_d;
  logic [JW-1:0]    j_q, j_d;
  logic [FIXED-1:0] in_q [NB_INPUT];
  logic [FIXED-1:0] out_data_q, out_data_d;
  logic [IW-1:0]    out_idx_q, out_idx_d;

  logic                    j_last, i_last, acc_clr, acc_en;
  logic [JW-1:0]           op_sel;
  logic signed [ACC_W-1:0] acc, prod, bias_ext, acc_final, scaled;
  logic [FIXED-1:0]        reduced;

  assign j_last  = (j_q == JW'(NB_INPUT - 1));
  assign i_last  = (i_q == IW'(NB_NEURONS - 1));
  assign acc_clr = ((state_q == ST_IDLE) && start) || ((state_q == ST_OUT) && out_ready);
  assign acc_en  = (state_q == ST_MAC) && (j_q != '0);
  // ROM data lags the address by one cycle, so MAC pairs w_data with the
  // previous input; in BIAS j still points at the last input.
  assign op_sel  = acc_en ? (j_q - JW'(1)) : j_q;

  dense_seq_mac #(
    .FIXED (FIXED),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clear_i (acc_clr),
    .en_i    (acc_en),
    .a_i     (in_q[op_sel]),
    .b_i     (w_data),
    .prod_o  (prod),
    .acc_o   (acc)
  );

  assign bias_ext  = {{(ACC_W-FIXED){b_data[FIXED-1]}}, b_data};
  assign acc_final = acc + prod + bias_ext;
  assign scaled    = acc_final >>> SCALE_SHIFT;

`ifdef DENSE_SEQ_SAT_EN
  assign reduced = saturate(scaled);
`else
  assign reduced = FIXED'(scaled);
`endif

  // Input vector is captured only when a pass is accepted.
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && start) begin
      for (int k = 0; k < NB_INPUT; k++) begin
        in_q[k] <= in_vec[k*FIXED +: FIXED];
      end
    end
  end

  // Pass sequencing: walk inputs per neuron, fold in bias, hold result until accepted.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_MAC;
          i_d     = '0;
          j_d     = '0;
        end
      end
      ST_MAC: begin
        if (j_last) begin
          state_d = ST_BIAS;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      ST_BIAS: begin
        out_data_d = reduced;
        out_idx_d  = i_q;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          if (i_last) begin
            state_d = ST_DONE;
          end else begin
            i_d     = i_q + IW'(1);
            j_d     = '0;
            state_d = ST_MAC;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign w_rd_en   = (state_q == ST_MAC);
  assign w_addr    = w_rd_en ? AW'(int'(j_q) * STRIDE + int'(i_q)) : '0;
  assign b_rd_en   = w_rd_en && j_last;
  assign b_addr    = b_rd_en ? i_q : '0;
  assign out_valid = (state_q == ST_OUT);
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_dense_mac_sequencer.sv
// tb/tb_dense_mac_sequencer.sv - directed and randomized self-checking bench for dense_mac_sequencer
module tb_dense_mac_sequencer;

  localparam int FIXED = 32;
  localparam int FRAC  = 16;
  localparam int NBI   = 2;
  localparam int NBN   = 2;
  localparam int STR   = 2;
  localparam int AW    = 2;
  localparam int IW    = 1;

  logic               clk = 1'b0;
  logic               rst, start, out_ready;
  logic [NBI*FIXED-1:0] in_vec;
  logic               busy, done, w_rd_en, b_rd_en, out_valid;
  logic [AW-1:0]      w_addr;
  logic [IW-1:0]      b_addr, out_idx;
  logic [FIXED-1:0]   w_data, b_data, out_data;

  int checks = 0;
  int errors = 0;

  int in_v  [NBI];
  int w_rom [NBI*STR];
  int b_rom [NBN];
  logic [31:0] last_data [NBN];

  always #5 clk = ~clk;

  dense_mac_sequencer #(
    .FIXED(FIXED), .FRAC(FRAC), .NB_INPUT(NBI), .NB_NEURONS(NBN),
    .STRIDE(STR), .SCALE_SHIFT(8), .ACC_W(48)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data)
  );

  // ROMs: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    w_data <= w_rd_en ? w_rom[w_addr] : $urandom;
    b_data <= b_rd_en ? b_rom[b_addr] : $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: dot product in 64-bit integers, wrapped to 48 bits, scaled, reduced.
  function automatic logic [31:0] model_out(int n);
    longint acc = 0;
    longint s;
    for (int k = 0; k < NBI; k++) begin
      acc += (longint'(in_v[k]) * longint'(w_rom[k*STR + n])) >>> FRAC;
    end
    acc += longint'(b_rom[n]);
    acc = (acc <<< 16) >>> 16;
    s = acc >>> 8;
`ifdef DENSE_SEQ_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  task automatic load_inputs();
    for (int k = 0; k < NBI; k++) in_vec[k*FIXED +: FIXED] = in_v[k];
  endtask

  task automatic randomize_data();
    for (int k = 0; k < NBI; k++) in_v[k] = $urandom;
    for (int k = 0; k < NBI*STR; k++) w_rom[k] = $urandom;
    for (int k = 0; k < NBN; k++) b_rom[k] = $urandom;
  endtask

  // One full pass from the current negedge; cycle c is the period after edge c.
  task automatic run_pass(input string tag, input int stall_n, input int stall_len,
                          input bit poke, output int first_valid, output int done_cyc);
    int          stall_left;
    bit          snap;
    logic [31:0] snap_d;
    logic [IW-1:0] snap_i;
    logic [AW-1:0] addr_q[$];
    int          idx_q[$];
    logic [31:0] dat_q[$];
    first_valid = -1;
    done_cyc    = -1;
    stall_left  = stall_len;
    snap        = 1'b0;
    snap_d      = '0;
    snap_i      = '0;
    load_inputs();
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      start = poke && (c == 3 || c == 5);
      if (w_rd_en) addr_q.push_back(w_addr);
      if (done && done_cyc < 0) done_cyc = c;
      if (out_valid) begin
        if (first_valid < 0) first_valid = c;
        if (int'(out_idx) == stall_n && stall_left > 0) begin
          if (!snap) begin
            snap   = 1'b1;
            snap_d = out_data;
            snap_i = out_idx;
          end else begin
            chk({tag, "_stall_data"}, out_data, snap_d);
            chk({tag, "_stall_idx"}, out_idx, snap_i);
          end
          chk({tag, "_stall_no_rd"}, {w_rd_en, b_rd_en}, 2'b00);
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          idx_q.push_back(int'(out_idx));
          dat_q.push_back(out_data);
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_done_seen"}, done_cyc >= 0, 1'b1);
    chk({tag, "_after_done"}, {busy, done}, 2'b00);
    chk({tag, "_n_out"}, idx_q.size(), NBN);
    for (int n = 0; n < NBN; n++) last_data[n] = '0;
    for (int n = 0; n < NBN && n < idx_q.size(); n++) begin
      last_data[n] = dat_q[n];
      chk({tag, "_idx"}, idx_q[n], n);
      chk({tag, "_data"}, dat_q[n], model_out(n));
    end
    chk({tag, "_n_addr"}, addr_q.size(), NBI*NBN);
    for (int n = 0; n < NBN; n++) begin
      for (int k = 0; k < NBI; k++) begin
        if (n*NBI + k < addr_q.size())
          chk({tag, "_w_addr"}, addr_q[n*NBI + k], k*STR + n);
      end
    end
  endtask

  initial begin
    int fv, dc;
    bit seen;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; in_vec = '0;
    for (int k = 0; k < NBI*STR; k++) w_rom[k] = 0;
    for (int k = 0; k < NBN; k++) b_rom[k] = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_en", {w_rd_en, b_rd_en}, 2'b00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_addr", {w_addr, b_addr}, '0);
    chk("rst_out", {out_idx, out_data}, '0);
    rst = 1'b0;
    @(negedge clk);

    in_v[0] = 32'h00010000; in_v[1] = 32'h00010000;
    for (int k = 0; k < NBI*STR; k++) w_rom[k] = 32'h00010000;
    run_pass("unity", -1, 0, 1'b0, fv, dc);
    chk("unity_first_valid", fv, 4);
    chk("unity_done_cyc", dc, 9);
    chk("unity_out0", last_data[0], 32'h00000200);
    chk("unity_out1", last_data[1], 32'h00000200);

    in_v[0] = 32'hFFFF0000; in_v[1] = 32'hFFFF0000;
    run_pass("neg_stall", 0, 5, 1'b1, fv, dc);
    chk("neg_first_valid", fv, 4);
    chk("neg_done_cyc", dc, 14);
    chk("neg_out0", last_data[0], 32'hFFFFFE00);
    chk("neg_out1", last_data[1], 32'hFFFFFE00);

    in_v[0] = 32'h7FFF0000; in_v[1] = 32'h7FFF0000;
    for (int k = 0; k < NBI*STR; k++) w_rom[k] = 32'h7FFF0000;
    run_pass("big", 1, 2, 1'b0, fv, dc);
`ifdef DENSE_SEQ_SAT_EN
    chk("big_out0", last_data[0], 32'h7FFFFFFF);
`else
    chk("big_out0", last_data[0], 32'hFE000200);
`endif

    randomize_data();
    load_inputs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_in_mac1", {w_rd_en, w_addr}, {1'b1, 2'd1});
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_rd", {w_rd_en, b_rd_en}, 2'b00);
    chk("midrst_out", {out_idx, out_data}, '0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("midrst_quiet", seen, 1'b0);
    run_pass("after_rst", -1, 0, 1'b0, fv, dc);

    for (int r = 0; r < 8; r++) begin
      randomize_data();
      run_pass("rand", $urandom_range(0, NBN-1), $urandom_range(0, 3), 1'($urandom), fv, dc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
